move_collector: RTL and testbench
=================================

# move_collector

Drains the eight per-column move FIFOs produced by the column units and serialises their 160-bit move words onto a single valid/ready stream for the move-evaluation stage. Columns are serviced round-robin, one word per visit; all-zero (PVOID-padded) words are discarded. When every column has raised its done flag and all FIFOs are empty, the block reports completion together with the count of words forwarded.

## Interface
- NCOL, 8, number of column units / FIFOs serviced
- W, 160, width of one FIFO word
- CNTW, 10, width of forwarded-word counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin a collection pass
- coldone  in  NCOL  per-column done flag from column units
- fifoEmpty  in  NCOL  per-column FIFO empty flag
- fifoOut  in  NCOL*W  concatenated FIFO read data; column c at bits [c*W +: W]
- rden  out  NCOL  per-column FIFO read enable, one-hot or zero
- mv_data  out  W  forwarded move word
- mv_col  out  3  source column of mv_data (0 = COLA … 7 = COLH)
- mv_valid  out  1  mv_data/mv_col valid
- mv_ready  in  1  downstream accepts when high with mv_valid
- mv_count  out  CNTW  words forwarded this pass, saturating
- busy  out  1  pass in progress
- all_done  out  1  pass complete; held until next start

## Operation
- States: IDLE, SCAN, READ, WAIT, HOLD, DONE.
- IDLE: start -> SCAN; ptr <= 0, mv_count <= 0, all_done <= 0.
- SCAN: search columns ptr, ptr+1, … mod NCOL for first c with fifoEmpty[c]=0. Found -> READ with sel <= c. None found and coldone all-ones -> DONE. Otherwise stay in SCAN.
- READ: rden[sel]=1 for exactly this cycle -> WAIT. FIFO is non-show-ahead: data valid the cycle after rden.
- WAIT: capture fifoOut[sel*W +: W] into mv_data, sel into mv_col. Captured word all-zero -> SCAN (discarded, not counted). Else -> HOLD.
- HOLD: mv_valid=1. mv_valid && mv_ready -> transfer; mv_count increments (saturates at 2^CNTW-1), ptr <= (sel+1) mod NCOL, -> SCAN. mv_data/mv_col stable while mv_valid && !mv_ready.
- After a discard, ptr also advances to (sel+1) mod NCOL.
- DONE: all_done=1; start -> IDLE-equivalent reinit and SCAN. Other inputs ignored.
- start while busy is ignored.
- busy = 1 in SCAN, READ, WAIT, HOLD.
- rden is never asserted outside READ; never asserted for a column whose fifoEmpty was high in the preceding SCAN cycle.
- Completion requires all coldone high and all fifoEmpty high in the same SCAN cycle; a column raising done with data still queued is drained first.

## Timing
- Reset (reset=0, async): state IDLE; rden=0, mv_valid=0, mv_data=0, mv_col=0, mv_count=0, busy=0, all_done=0, ptr=0. Outputs clear immediately, independent of clk; a reset during READ drops rden without waiting for the edge.
- start sampled at edge N -> SCAN at N+1, busy high from N+1.
- Minimum per-word path: SCAN 1 cycle, READ 1, WAIT 1, HOLD ≥1 -> 4 cycles/word with mv_ready held high.
- mv_valid rises the cycle after WAIT; falls the cycle after the accepting edge.
- Final edge: DONE entered one cycle after the qualifying SCAN; all_done and busy=0 both change on that edge.
- mv_count updates on the transfer edge; value visible with all_done is final.

## Test plan
- Reset mid-pass: assert reset=0 while rden[3]=1 -> rden=0, mv_valid=0, mv_count=0, all_done=0 immediately; no further reads until new start.
- Single column: only column 3 (COLD) non-empty with 2 non-zero words, all coldone=1, mv_ready=1 -> two transfers, mv_col=3 both, rden[3] pulsed twice 4 cycles apart, all_done=1, mv_count=2.
- Round-robin fairness: columns 0, 2, 7 each hold 2 words -> mv_col order 0,2,7,0,2,7; mv_count=6.
- Backpressure: mv_ready=0 for 10 cycles in HOLD -> mv_valid stays 1, mv_data unchanged, no rden pulses; on mv_ready=1 exactly one transfer.
- Zero filtering: column 5 holds {0, 160'h1A5, 0} -> one transfer of 160'h1A5, mv_count=1, three rden[5] pulses.
- Late done: all FIFOs empty, coldone=8'h7F for 20 cycles then 8'hFF -> all_done stays 0 until one cycle after bit 7 rises, mv_count=0; start during busy ignored.

Source files
------------

// File: rtl/move_collector_if.sv
// Move stream between the collector and the move-evaluation stage.
interface move_collector_if #(
    parameter int unsigned W = 160
);
    logic [W-1:0] mv_data;
    logic [2:0]   mv_col;
    logic         mv_valid;
    logic         mv_ready;

    modport master (
        output mv_data,
        output mv_col,
        output mv_valid,
        input  mv_ready
    );

    modport slave (
        input  mv_data,
        input  mv_col,
        input  mv_valid,
        output mv_ready
    );
endinterface

// File: rtl/move_collector.sv
// Round-robin drain of the per-column move FIFOs onto one valid/ready stream.
// All-zero (padding) words are dropped; completion is reported once every column is
// done and every FIFO is empty, together with the saturating count of forwarded words.
module move_collector #(
    parameter int unsigned NCOL = 8,
    parameter int unsigned W    = 160,
    parameter int unsigned CNTW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NCOL-1:0]   coldone,
    input  logic [NCOL-1:0]   fifoEmpty,
    input  logic [NCOL*W-1:0] fifoOut,
    output logic [NCOL-1:0]   rden,
    move_collector_if.master  mv,
    output logic [CNTW-1:0]   mv_count,
    output logic              busy,
    output logic              all_done
);
    localparam int unsigned PW = (NCOL > 1) ? $clog2(NCOL) : 1;

    typedef enum logic [2:0] {StIdle, StScan, StRead, StWait, StHold, StDone} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   sel_q, sel_d;
    logic [W-1:0]    data_q, data_d;
    logic [2:0]      col_q, col_d;
    logic [CNTW-1:0] count_q, count_d;

    logic            found;
    logic [PW-1:0]   found_col;
    int unsigned     scan_pos;
    logic [PW-1:0]   scan_idx;
    logic [PW-1:0]   next_sel;
    logic [W-1:0]    word;

    // Column after the one just serviced; the next search starts there.
    assign next_sel = (32'(sel_q) == NCOL - 1) ? '0 : sel_q + 1'b1;
    // Non-show-ahead FIFO: this is the word read in the previous (READ) cycle.
    assign word     = fifoOut[32'(sel_q) * W +: W];

    // First non-empty column at or after ptr, wrapping around.
    always_comb begin
        found     = 1'b0;
        found_col = '0;
        scan_pos  = 0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < NCOL; i++) begin
            scan_pos = 32'(ptr_q) + i;
            if (scan_pos >= NCOL) scan_pos = scan_pos - NCOL;
            scan_idx = PW'(scan_pos);
            if (!found && !fifoEmpty[scan_idx]) begin
                found     = 1'b1;
                found_col = scan_idx;
            end
        end
    end

    // Next-state logic for the pass sequencer and its datapath registers.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        col_d   = col_q;
        count_d = count_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StScan;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end
            StScan: begin
                if (found) begin
                    sel_d   = found_col;
                    state_d = StRead;
                end else if (&coldone) begin
                    state_d = StDone;
                end
            end
            StRead: state_d = StWait;
            StWait: begin
                data_d = word;
                col_d  = 3'(sel_q);
                if (word == '0) begin
                    ptr_d   = next_sel;
                    state_d = StScan;
                end else begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (mv.mv_ready) begin
                    if (count_q != '1) count_d = count_q + 1'b1;
                    ptr_d   = next_sel;
                    state_d = StScan;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset clears every output immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            col_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            col_q   <= col_d;
            count_q <= count_d;
        end
    end

    // Read strobe is decoded from state so it drops with the asynchronous reset.
    always_comb begin
        rden = '0;
        if (state_q == StRead) rden[sel_q] = 1'b1;
    end

    assign mv.mv_data  = data_q;
    assign mv.mv_col   = col_q;
    assign mv.mv_valid = (state_q == StHold);
    assign mv_count    = count_q;
    assign busy        = (state_q == StScan) || (state_q == StRead) ||
                         (state_q == StWait) || (state_q == StHold);
    assign all_done    = (state_q == StDone);
endmodule

// File: tb/tb_move_collector.sv
// Scoreboard bench for move_collector: FIFO model, round-robin reference model,
// decoupled stream monitor.
module tb_move_collector;
    localparam int unsigned NCOL = 8;
    localparam int unsigned W    = 160;
    localparam int unsigned CNTW = 10;
    localparam int          CMAX = (1 << CNTW) - 1;

    typedef struct packed {
        logic [2:0]   col;
        logic [W-1:0] data;
    } xfer_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [NCOL-1:0]   coldone;
    logic [NCOL-1:0]   fifo_empty = '1;
    logic [NCOL*W-1:0] fifo_out   = '0;
    logic [NCOL-1:0]   rden;
    logic [CNTW-1:0]   mv_count;
    logic              busy;
    logic              all_done;

    move_collector_if #(.W(W)) mv ();

    move_collector #(.NCOL(NCOL), .W(W), .CNTW(CNTW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .coldone   (coldone),
        .fifoEmpty (fifo_empty),
        .fifoOut   (fifo_out),
        .rden      (rden),
        .mv        (mv),
        .mv_count  (mv_count),
        .busy      (busy),
        .all_done  (all_done)
    );

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] fifo_q [NCOL][$];
    xfer_t        exp_q [$];
    int           rden_pulses = 0;
    int           cycle = 0;
    int           last_rden_cycle = 0;
    int           last_gap = 0;
    bit           ready_rand = 1'b0;
    bit           ready_low = 1'b0;

    initial forever #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Non-show-ahead FIFOs: read data appears the cycle after rden.
    always @(posedge clk) begin
        for (int c = 0; c < NCOL; c++) begin
            if (reset && rden[c] && fifo_q[c].size() > 0)
                fifo_out[c*W +: W] <= fifo_q[c].pop_front();
            fifo_empty[c] <= (fifo_q[c].size() == 0);
        end
    end

    // Downstream ready: forced low, random, or always high.
    initial begin
        mv.mv_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_low) mv.mv_ready = 1'b0;
            else if (ready_rand) mv.mv_ready = ($urandom_range(3) != 0);
            else mv.mv_ready = 1'b1;
        end
    end

    // Monitor: read strobe legality, hold stability, and scoreboard compare on transfer.
    initial begin
        logic [W-1:0] hold_data;
        logic [2:0]   hold_col;
        bit           holding;
        xfer_t        e;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            cycle++;
            if (!reset) begin
                holding = 1'b0;
                continue;
            end
            if (rden != '0) begin
                rden_pulses++;
                last_gap        = cycle - last_rden_cycle;
                last_rden_cycle = cycle;
                check("rden_onehot", $countones(rden), 1);
                check("rden_nonempty", rden & fifo_empty, 0);
            end
            if (holding) begin
                check("hold_valid", mv.mv_valid, 1);
                check("hold_data", mv.mv_data, hold_data);
                check("hold_col", mv.mv_col, hold_col);
                check("hold_no_rden", rden, 0);
            end
            if (mv.mv_valid && mv.mv_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_xfer: got col %0d data %0h, expected none",
                             mv.mv_col, mv.mv_data);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_data", mv.mv_data, e.data);
                    check("xfer_col", mv.mv_col, e.col);
                end
                holding = 1'b0;
            end else if (mv.mv_valid) begin
                holding   = 1'b1;
                hold_data = mv.mv_data;
                hold_col  = mv.mv_col;
            end else begin
                holding = 1'b0;
            end
        end
    end

    // Reference: repeatedly take the first non-empty column from ptr, forward non-zero words.
    task automatic model(output int total, output int expcnt);
        logic [W-1:0] m [NCOL][$];
        int           ptr;
        int           nz;
        bit           any;
        logic [W-1:0] w;
        xfer_t        e;
        for (int c = 0; c < NCOL; c++) m[c] = fifo_q[c];
        ptr   = 0;
        total = 0;
        nz    = 0;
        any   = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int k = 0; k < NCOL && !any; k++) begin
                int c;
                c = (ptr + k) % NCOL;
                if (m[c].size() > 0) begin
                    any = 1'b1;
                    w   = m[c].pop_front();
                    total++;
                    if (w != '0) begin
                        e.col  = 3'(c);
                        e.data = w;
                        exp_q.push_back(e);
                        nz++;
                    end
                    ptr = (c + 1) % NCOL;
                end
            end
        end
        expcnt = (nz > CMAX) ? CMAX : nz;
    endtask

    task automatic clear_fifos();
        for (int c = 0; c < NCOL; c++) fifo_q[c].delete();
    endtask

    task automatic load(input int c, input logic [W-1:0] w);
        fifo_q[c].push_back(w);
    endtask

    task automatic start_pass(output int total, output int expcnt, output int p0);
        model(total, expcnt);
        coldone = '1;
        p0      = rden_pulses;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
    endtask

    task automatic end_pass(input string name, input int budget, input int total,
                            input int expcnt, input int p0);
        int n;
        n = 0;
        while (!all_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_all_done"}, all_done, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_count"}, mv_count, expcnt);
        check({name, "_reads"}, rden_pulses - p0, total);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic run_pass(input string name, input int budget);
        int total, expcnt, p0;
        start_pass(total, expcnt, p0);
        end_pass(name, budget, total, expcnt, p0);
    endtask

    function automatic logic [W-1:0] rand_word();
        if ($urandom_range(3) == 0) return '0;
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int           total, expcnt, p0, p1, n, seen;
        logic [W-1:0] d;
        reset   = 1'b0;
        start   = 1'b0;
        coldone = '0;
        repeat (3) @(negedge clk);
        check("rst_rden", rden, 0);
        check("rst_valid", mv.mv_valid, 0);
        check("rst_data", mv.mv_data, 0);
        check("rst_col", mv.mv_col, 0);
        check("rst_count", mv_count, 0);
        check("rst_busy", busy, 0);
        check("rst_all_done", all_done, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Only column 3 holds data.
        clear_fifos();
        load(3, 160'hDEAD_0001);
        load(3, 160'hBEEF_0002);
        run_pass("single", 200);
        check("single_gap", last_gap, 4);
        check("single_count", mv_count, 2);

        // Round-robin fairness over columns 0, 2, 7.
        for (int r = 0; r < 2; r++) begin
            load(0, 160'(32'h100 + r));
            load(2, 160'(32'h200 + r));
            load(7, 160'(32'h700 + r));
        end
        run_pass("rr", 300);
        check("rr_count", mv_count, 6);

        // Backpressure for ten cycles in HOLD.
        load(1, 160'h5A5A_1234);
        ready_low = 1'b1;
        start_pass(total, expcnt, p0);
        n = 0;
        while (!mv.mv_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", mv.mv_valid, 1);
        check("bp_data", mv.mv_data, 160'h5A5A_1234);
        d  = mv.mv_data;
        p1 = rden_pulses;
        repeat (10) begin
            @(negedge clk);
            check("bp_stable_valid", mv.mv_valid, 1);
            check("bp_stable_data", mv.mv_data, d);
        end
        check("bp_no_reads", rden_pulses, p1);
        ready_low = 1'b0;
        end_pass("bp", 100, total, expcnt, p0);

        // Zero-word filtering on column 5.
        load(5, 160'h0);
        load(5, 160'h1A5);
        load(5, 160'h0);
        run_pass("zero", 200);
        check("zero_count", mv_count, 1);

        // Late done: every FIFO empty, column 7 finishes after 20 cycles.
        clear_fifos();
        coldone = 8'h7F;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("late_all_done", all_done, 0);
            check("late_busy", busy, 1);
        end
        check("late_count_busy", mv_count, 0);
        coldone = 8'hFF;
        #1;
        check("late_before_edge", all_done, 0);
        @(negedge clk);
        check("late_done", all_done, 1);
        check("late_idle", busy, 0);
        check("late_count", mv_count, 0);

        // Reset in the middle of a pass, on the second READ of column 3.
        load(3, 160'hC0FFEE);
        load(3, 160'hF00D);
        model(total, expcnt);
        coldone = '1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        n     = 0;
        while (seen < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (rden[3]) seen++;
        end
        check("mid_reads_seen", seen, 2);
        check("mid_count_before", mv_count, 1);
        #1 reset = 1'b0;
        #1;
        check("mid_rden", rden, 0);
        check("mid_valid", mv.mv_valid, 0);
        check("mid_count", mv_count, 0);
        check("mid_all_done", all_done, 0);
        check("mid_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        #1 reset = 1'b1;
        p1 = rden_pulses;
        repeat (8) @(negedge clk);
        check("mid_no_reads", rden_pulses, p1);
        check("mid_idle", busy, 0);
        clear_fifos();
        @(negedge clk);

        // Forwarded-word counter saturation.
        for (int i = 0; i < 1030; i++) load(0, 160'(i + 1));
        run_pass("sat", 6000);
        check("sat_count", mv_count, CMAX);

        // Randomised passes with random downstream backpressure.
        ready_rand = 1'b1;
        for (int p = 0; p < 8; p++) begin
            clear_fifos();
            for (int c = 0; c < NCOL; c++) begin
                n = $urandom_range(4);
                for (int k = 0; k < n; k++) load(c, rand_word());
            end
            n = 0;
            for (int c = 0; c < NCOL; c++) n += fifo_q[c].size();
            run_pass("rand", 100 + n * 60);
        end
        ready_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
